instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  in  1  clock; all state SHALL update on rising edge only.
REQ-003 rstn  in  1  reset, synchronous, active-low.
REQ-004 if_stall  in  1  downstream hold; presented instruction SHALL NOT be consumed while high.
REQ-005 redirect_valid  in  1  redirect request (branch/jump/flush).
REQ-006 redirect_pc  in  32  redirect target address.
REQ-007 imem_req_valid  out  1  memory request valid.
REQ-008 imem_req_ready  in  1  memory accepts request; handshake = valid & ready.
REQ-009 imem_req_addr  out  32  request address; SHALL equal pc whenever imem_req_valid is high.
REQ-010 imem_rsp_valid  in  1  response valid; at most one per accepted request, in order, no earlier than one cycle after acceptance.
REQ-011 imem_rsp_data  in  32  response instruction word.
REQ-012 if_pc / if_pc_p4 / if_instr  out  32 each  presented instruction address, address+4, instruction word.
REQ-013 if_valid  out  1  presented instruction valid; consumed when if_valid & ~if_stall & ~redirect_valid.

Function
REQ-014 States SHALL be REQ, WAIT, VALID, DRAIN; at most one request outstanding at any time.
REQ-015 REQ: imem_req_valid=1; handshake -> WAIT; no handshake -> stay REQ.
REQ-016 WAIT: imem_req_valid=0; imem_rsp_valid -> capture if_pc=pc, if_pc_p4=pc+4, if_instr=imem_rsp_data, if_valid=1 next cycle, state -> VALID.
REQ-017 VALID: outputs held stable while if_stall=1; on consume, pc <= pc+4 and imem_req_valid=1 with imem_req_addr=pc+4 in the same cycle (combinational); handshake -> WAIT, else -> REQ; if_valid -> 0 next cycle.
REQ-018 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
REQ-019 redirect_valid SHALL take priority over every other event in every state: pc <= redirect_pc, if_valid -> 0 next cycle.
REQ-020 Redirect in REQ without handshake, in VALID, or in WAIT coincident with imem_rsp_valid -> REQ; that response SHALL be discarded.
REQ-021 Redirect in WAIT without response, or coincident with a request handshake in REQ/VALID -> DRAIN.
REQ-022 DRAIN: imem_req_valid=0; next imem_rsp_valid SHALL be discarded and state -> REQ; further redirects in DRAIN update pc only.
REQ-023 A discarded response SHALL never alter if_pc, if_pc_p4, if_instr or if_valid.
REQ-024 if_valid SHALL be 0 in REQ, WAIT, DRAIN.

Reset
REQ-025 rstn=0 at a clock edge SHALL set state=REQ, pc=RESET_PC, if_valid=0, if_pc=if_pc_p4=if_instr=0, misalign flag=0, regardless of outstanding requests.
REQ-026 First cycle with rstn=1: imem_req_valid=1, imem_req_addr=RESET_PC.
REQ-027 A response to a request accepted before reset SHALL be the memory's responsibility to suppress (memory shares rstn).

Configuration
REQ-028 Macro INSTR_FETCH_MISALIGN_EN defined: extra output fetch_misalign (1 bit); redirect with redirect_pc[1:0]!=0 SHALL set it next cycle, load pc=redirect_pc, state -> REQ held with imem_req_valid=0 (or DRAIN first if REQ-021 applies) until a later aligned redirect clears it.
REQ-029 Macro undefined: no fetch_misalign port; redirect_pc[1:0] SHALL be ignored and pc loaded as {redirect_pc[31:2],2'b00}.

Verification
REQ-030 Reset then imem_req_ready=1, 1-cycle response 32'h0000_0013 -> imem_req_addr=0, if_valid=1 with if_pc=0, if_pc_p4=4, if_instr=32'h13; back-to-back addresses 0,4,8.
REQ-031 if_stall=1 for 3 cycles in VALID with if_instr=32'h00A00093 -> outputs unchanged, imem_req_valid=0; release -> request addr pc+4 same cycle.
REQ-032 Redirect to 32'h0000_0100 while WAIT -> DRAIN; stale response discarded (if_valid stays 0); next request addr 32'h100.
REQ-033 Redirect to 32'h200 coincident with imem_rsp_valid in WAIT -> response discarded, next cycle REQ with addr 32'h200.
REQ-034 pc=32'hFFFF_FFFC consumed -> next request addr 32'h0000_0000, if_pc_p4 was 32'h0.
REQ-035 With INSTR_FETCH_MISALIGN_EN, redirect to 32'h102 -> fetch_misalign=1, no requests; redirect to 32'h104 -> flag clears, request addr 32'h104; without macro redirect to 32'h102 -> request addr 32'h100.

Source files
------------

// File: rtl/instr_fetch_if.sv
// ============================================================================
// Module      : instr_fetch_if
// Description : Instruction-memory request/response bus between fetch and imem.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instr_fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// Module      : instr_fetch
// Description : Single-outstanding instruction fetch with redirect and drain.
//               Optional macro INSTR_FETCH_MISALIGN_EN adds fetch_misalign.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  wire logic        clk,
  input  wire logic        rstn,
  input  wire logic        if_stall,
  input  wire logic        redirect_valid,
  input  wire logic [31:0] redirect_pc,
  instr_fetch_if.master    imem,
  output logic [31:0]      if_pc,
  output logic [31:0]      if_pc_p4,
  output logic [31:0]      if_instr,
  output logic             if_valid
`ifdef INSTR_FETCH_MISALIGN_EN
  ,
  output logic             fetch_misalign
`endif
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_pc_p4;
  logic [31:0] r_if_instr;
  logic        r_if_valid;

  logic [31:0] w_pc_p4;
  logic [31:0] w_redir_pc;
  logic        w_req_block;
  logic        w_req_valid;
  logic [31:0] w_req_addr;
  logic        w_hs;

  assign w_pc_p4 = r_pc + 32'd4;

`ifdef INSTR_FETCH_MISALIGN_EN
  logic r_misalign;
  assign w_redir_pc     = redirect_pc;
  assign w_req_block    = r_misalign;
  assign fetch_misalign = r_misalign;
`else
  assign w_redir_pc  = redirect_pc & ~32'd3;
  assign w_req_block = 1'b0;
`endif

  // In VALID the next request goes out in the consume cycle, so it targets pc+4.
  always_comb begin
    w_req_valid = 1'b0;
    w_req_addr  = r_pc;
    case (r_state)
      S_REQ:   w_req_valid = ~w_req_block;
      S_VALID: begin
        w_req_valid = ~if_stall & ~redirect_valid;
        w_req_addr  = w_pc_p4;
      end
      default: w_req_valid = 1'b0;
    endcase
  end

  assign w_hs                = w_req_valid & imem.imem_req_ready;
  assign imem.imem_req_valid = w_req_valid;
  assign imem.imem_req_addr  = w_req_addr;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= S_REQ;
      r_pc       <= RESET_PC;
      r_if_pc    <= 32'd0;
      r_if_pc_p4 <= 32'd0;
      r_if_instr <= 32'd0;
      r_if_valid <= 1'b0;
`ifdef INSTR_FETCH_MISALIGN_EN
      r_misalign <= 1'b0;
`endif
    end else if (redirect_valid) begin
      r_pc       <= w_redir_pc;
      r_if_valid <= 1'b0;
`ifdef INSTR_FETCH_MISALIGN_EN
      r_misalign <= |redirect_pc[1:0];
`endif
      // An accepted-but-unanswered request must be drained before refetching.
      case (r_state)
        S_REQ:   r_state <= w_hs ? S_DRAIN : S_REQ;
        S_VALID: r_state <= w_hs ? S_DRAIN : S_REQ;
        default: r_state <= imem.imem_rsp_valid ? S_REQ : S_DRAIN;
      endcase
    end else begin
      case (r_state)
        S_REQ: begin
          if (w_hs) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem.imem_rsp_valid) begin
            r_if_pc    <= r_pc;
            r_if_pc_p4 <= w_pc_p4;
            r_if_instr <= imem.imem_rsp_data;
            r_if_valid <= 1'b1;
            r_state    <= S_VALID;
          end
        end
        S_VALID: begin
          if (!if_stall) begin
            r_pc       <= w_pc_p4;
            r_if_valid <= 1'b0;
            r_state    <= w_hs ? S_WAIT : S_REQ;
          end
        end
        default: begin
          if (imem.imem_rsp_valid) r_state <= S_REQ;
        end
      endcase
    end
  end

  assign if_pc    = r_if_pc;
  assign if_pc_p4 = r_if_pc_p4;
  assign if_instr = r_if_instr;
  assign if_valid = r_if_valid;

endmodule

`default_nettype wire
